// File: rtl/inst_trace_buf_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : riscv_trace_pkg                                             |
// | Desc   : Shared encodings, instruction field ranges and trace states |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
package riscv_trace_pkg;

    localparam int c_opcode_hi = 31;
    localparam int c_opcode_lo = 25;
    localparam int c_ra_hi     = 24;
    localparam int c_ra_lo     = 20;
    localparam int c_rb_hi     = 19;
    localparam int c_rb_lo     = 15;
    localparam int c_rc_hi     = 4;
    localparam int c_rc_lo     = 0;
    localparam int c_shamt_hi  = 5;
    localparam int c_shamt_lo  = 0;
    localparam int c_imm_hi    = 11;
    localparam int c_imm_lo    = 0;
    localparam int c_bigimm_hi = 19;
    localparam int c_bigimm_lo = 0;
    localparam int c_target_hi = 26;
    localparam int c_target_lo = 0;

    localparam logic [6:0]  c_op_addi   = 7'h08;
    localparam logic [6:0]  c_op_branch = 7'h30;
    // NOP is ADDI with every register and immediate field zero
    localparam logic [31:0] c_nop       = {c_op_addi, 25'd0};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_POST   = 2'd2,
        ST_FROZEN = 2'd3
    } trace_state_t;

endpackage
`default_nettype wire

// File: rtl/inst_trace_buf_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : inst_trace_buf_if                                           |
// | Desc   : Retire-lane input bus and decoded valid/ready drain port    |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
interface inst_trace_buf_if #(
    parameter int LANES = 2
);
    logic [LANES-1:0]    ret_valid;
    logic [32*LANES-1:0] ret_pc;
    logic [32*LANES-1:0] ret_inst;

    logic                out_valid;
    logic                out_ready;
    logic [31:0]         out_pc;
    logic [31:0]         out_inst;
    logic [1:0]          out_lane;
    logic [4:0]          out_ra;
    logic [4:0]          out_rb;
    logic [4:0]          out_rc;
    logic [11:0]         out_imm;
    logic [5:0]          out_shamt;

    modport master (
        output ret_valid, ret_pc, ret_inst, out_ready,
        input  out_valid, out_pc, out_inst, out_lane,
               out_ra, out_rb, out_rc, out_imm, out_shamt
    );

    modport slave (
        input  ret_valid, ret_pc, ret_inst, out_ready,
        output out_valid, out_pc, out_inst, out_lane,
               out_ra, out_rb, out_rc, out_imm, out_shamt
    );
endinterface
`default_nettype wire

// File: rtl/inst_trace_buf_unpack.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : inst_field_unpack                                           |
// | Desc   : Combinational split of a 32-bit instruction into fields     |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module inst_field_unpack
    import riscv_trace_pkg::*;
(
    input  wire logic [31:0] i_inst,
    output logic [6:0]       o_opcode,
    output logic [4:0]       o_ra,
    output logic [4:0]       o_rb,
    output logic [4:0]       o_rc,
    output logic [5:0]       o_shamt,
    output logic [11:0]      o_imm
);
    assign o_opcode = i_inst[c_opcode_hi:c_opcode_lo];
    assign o_ra     = i_inst[c_ra_hi:c_ra_lo];
    assign o_rb     = i_inst[c_rb_hi:c_rb_lo];
    assign o_rc     = i_inst[c_rc_hi:c_rc_lo];
    assign o_shamt  = i_inst[c_shamt_hi:c_shamt_lo];
    assign o_imm    = i_inst[c_imm_hi:c_imm_lo];
endmodule
`default_nettype wire

// File: rtl/inst_trace_buf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : inst_trace_buf                                              |
// | Desc   : Multi-lane retire trace buffer with trigger/post capture    |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module inst_trace_buf
    import riscv_trace_pkg::*;
#(
    parameter int LANES = 2,
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH)
) (
    input  wire logic           clk,
    input  wire logic           reset,
    inst_trace_buf_if.slave     bus,
    input  wire logic           arm,
    input  wire logic           disarm,
    input  wire logic [CW:0]    post_cnt,
    input  wire logic [31:0]    trig_val,
    input  wire logic [31:0]    trig_mask,
    input  wire logic [6:0]     filt_val,
    input  wire logic [6:0]     filt_mask,
    input  wire logic           drop_nop,
    output logic [CW:0]         count,
    output logic [1:0]          state,
    output logic [CW-1:0]       trig_idx
);

    logic [31:0]   r_mem_pc   [DEPTH];
    logic [31:0]   r_mem_inst [DEPTH];
    logic [1:0]    r_mem_lane [DEPTH];

    trace_state_t  r_state, w_state_nxt, w_cap_state;
    logic [CW-1:0] r_head, r_tail, r_trig_idx;
    logic [CW:0]   r_count, r_remaining, r_post_cnt;
    logic [31:0]   r_trig_val, r_trig_mask;
    logic [6:0]    r_filt_val, r_filt_mask;
    logic          r_drop_nop;

    logic [LANES-1:0] w_acc, w_trig, w_we;
    logic [CW-1:0]    w_waddr [LANES];
    logic [CW-1:0]    w_trig_addr, w_head_nxt, w_tail_nxt;
    logic             w_trig_hit, w_arm_go, w_pop;
    logic [2:0]       w_n_armed, w_n_post;
    logic [CW:0]      w_rem_nxt, w_cap, w_count_nxt;
    logic [CW+1:0]    w_cnt_full;
    logic             w_unused_cnt_msb;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [31:0] w_inst;
            logic [6:0]  w_op;
            logic [4:0]  w_unused_ra, w_unused_rb, w_unused_rc;
            logic [5:0]  w_unused_shamt;
            logic [11:0] w_unused_imm;

            assign w_inst = bus.ret_inst[32*gi +: 32];

            inst_field_unpack u_unpack (
                .i_inst   (w_inst),
                .o_opcode (w_op),
                .o_ra     (w_unused_ra),
                .o_rb     (w_unused_rb),
                .o_rc     (w_unused_rc),
                .o_shamt  (w_unused_shamt),
                .o_imm    (w_unused_imm)
            );

            assign w_acc[gi]  = bus.ret_valid[gi]
                             && ((w_op & r_filt_mask) == (r_filt_val & r_filt_mask))
                             && !(r_drop_nop && (w_inst == c_nop));
            assign w_trig[gi] = ((w_inst & r_trig_mask) == (r_trig_val & r_trig_mask));
        end
    endgenerate

    // Pre-trigger occupancy limit that reserves room for the post-trigger tail
    assign w_cap = (r_post_cnt > (CW+1)'(DEPTH-1)) ? (CW+1)'(1)
                                                   : (CW+1)'(DEPTH) - r_post_cnt;

    // Walk lanes in ascending order, letting the capture state evolve mid-bundle
    always_comb begin
        trace_state_t v_cur;
        logic [CW:0]  v_rem;
        logic [2:0]   v_slot;
        v_cur       = r_state;
        v_rem       = r_remaining;
        v_slot      = 3'd0;
        w_we        = '0;
        w_trig_hit  = 1'b0;
        w_trig_addr = r_tail;
        w_n_armed   = 3'd0;
        w_n_post    = 3'd0;
        for (int i = 0; i < LANES; i++) begin
            w_waddr[i] = r_tail + CW'(v_slot);
            if (w_acc[i] && (v_cur == ST_ARMED || v_cur == ST_POST)) begin
                w_we[i] = 1'b1;
                v_slot  = v_slot + 3'd1;
                if (v_cur == ST_ARMED) begin
                    w_n_armed = w_n_armed + 3'd1;
                    if (w_trig[i]) begin
                        w_trig_hit  = 1'b1;
                        w_trig_addr = w_waddr[i];
                        v_rem       = r_post_cnt;
                        v_cur       = (r_post_cnt == '0) ? ST_FROZEN : ST_POST;
                    end
                end else begin
                    w_n_post = w_n_post + 3'd1;
                    v_rem    = v_rem - 1'b1;
                    if (v_rem == '0) begin
                        v_cur = ST_FROZEN;
                    end
                end
            end
        end
        w_cap_state = v_cur;
        w_rem_nxt   = v_rem;
    end

    assign w_arm_go = arm && !disarm && (r_state == ST_IDLE || r_state == ST_FROZEN);
    assign w_pop    = bus.out_valid && bus.out_ready;

    always_comb begin
        w_state_nxt = w_cap_state;
        if (disarm && (r_state == ST_ARMED || r_state == ST_POST)) begin
            w_state_nxt = ST_FROZEN;
        end else if (w_arm_go) begin
            w_state_nxt = ST_ARMED;
        end
    end

    // Overflow only drops entries written before the trigger; DEPTH is the hard bound
    always_comb begin
        logic [CW+1:0] v_c1;
        logic [CW-1:0] v_drop;
        v_c1   = {1'b0, r_count} + (CW+2)'(w_n_armed);
        v_drop = '0;
        if (w_n_armed != 3'd0 && v_c1 > {1'b0, w_cap}) begin
            v_drop = CW'(v_c1 - {1'b0, w_cap});
            v_c1   = {1'b0, w_cap};
        end
        w_cnt_full = v_c1 + (CW+2)'(w_n_post);
        if (w_cnt_full > (CW+2)'(DEPTH)) begin
            v_drop     = v_drop + CW'(w_cnt_full - (CW+2)'(DEPTH));
            w_cnt_full = (CW+2)'(DEPTH);
        end
        w_head_nxt  = r_head + v_drop;
        w_tail_nxt  = r_tail + CW'(w_n_armed + w_n_post);
        w_count_nxt = w_cnt_full[CW:0];
        if (w_arm_go) begin
            w_head_nxt  = '0;
            w_tail_nxt  = '0;
            w_count_nxt = '0;
        end else if (w_pop) begin
            w_head_nxt  = r_head + 1'b1;
            w_count_nxt = r_count - 1'b1;
        end
    end

    assign w_unused_cnt_msb = w_cnt_full[CW+1];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_remaining <= '0;
            r_trig_idx  <= '0;
            r_post_cnt  <= '0;
            r_trig_val  <= '0;
            r_trig_mask <= '0;
            r_filt_val  <= '0;
            r_filt_mask <= '0;
            r_drop_nop  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_head      <= w_head_nxt;
            r_tail      <= w_tail_nxt;
            r_count     <= w_count_nxt;
            r_remaining <= w_rem_nxt;
            if (w_trig_hit) begin
                r_trig_idx <= w_trig_addr;
            end
            if (w_arm_go) begin
                r_post_cnt  <= post_cnt;
                r_trig_val  <= trig_val;
                r_trig_mask <= trig_mask;
                r_filt_val  <= filt_val;
                r_filt_mask <= filt_mask;
                r_drop_nop  <= drop_nop;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (w_we[i]) begin
                r_mem_pc[w_waddr[i]]   <= bus.ret_pc[32*i +: 32];
                r_mem_inst[w_waddr[i]] <= bus.ret_inst[32*i +: 32];
                r_mem_lane[w_waddr[i]] <= 2'(i);
            end
        end
    end

    logic [6:0] w_unused_rd_op;

    inst_field_unpack u_rd_unpack (
        .i_inst   (r_mem_inst[r_head]),
        .o_opcode (w_unused_rd_op),
        .o_ra     (bus.out_ra),
        .o_rb     (bus.out_rb),
        .o_rc     (bus.out_rc),
        .o_shamt  (bus.out_shamt),
        .o_imm    (bus.out_imm)
    );

    assign bus.out_valid = (r_count != '0) && (r_state == ST_IDLE || r_state == ST_FROZEN);
    assign bus.out_pc    = r_mem_pc[r_head];
    assign bus.out_inst  = r_mem_inst[r_head];
    assign bus.out_lane  = r_mem_lane[r_head];
    assign count         = r_count;
    assign state         = r_state;
    assign trig_idx      = r_trig_idx;

endmodule
`default_nettype wire

// File: tb/tb_inst_trace_buf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_inst_trace_buf                                           |
// | Desc   : Directed self-checking bench for inst_trace_buf             |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_inst_trace_buf;
    import riscv_trace_pkg::*;

    logic        clk;
    logic        reset;
    logic        arm, disarm, drop_nop;
    logic [4:0]  post_cnt;
    logic [31:0] trig_val, trig_mask;
    logic [6:0]  filt_val, filt_mask;
    logic [4:0]  count;
    logic [1:0]  state;
    logic [3:0]  trig_idx;

    int n_chk  = 0;
    int n_pass = 0;

    inst_trace_buf_if #(.LANES(2)) bus ();

    inst_trace_buf #(.LANES(2), .DEPTH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .arm       (arm),
        .disarm    (disarm),
        .post_cnt  (post_cnt),
        .trig_val  (trig_val),
        .trig_mask (trig_mask),
        .filt_val  (filt_val),
        .filt_mask (filt_mask),
        .drop_nop  (drop_nop),
        .count     (count),
        .state     (state),
        .trig_idx  (trig_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input int k);
        return 32'h0200_0000 | 32'(k);
    endfunction

    function automatic logic [31:0] mkbr(input logic [4:0] ra, input logic [4:0] rb,
                                         input logic [11:0] imm);
        return {c_op_branch, ra, rb, 3'b000, imm};
    endfunction

    task automatic drive(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] i1);
        bus.ret_valid = v;
        bus.ret_inst  = {i1, i0};
        bus.ret_pc    = {i1 ^ 32'hFFFF_0000, i0 ^ 32'hFFFF_0000};
        cyc();
        bus.ret_valid = 2'b00;
    endtask

    task automatic do_arm(input logic [4:0] pc, input logic [31:0] tv, input logic [31:0] tm,
                          input logic [6:0] fv, input logic [6:0] fm, input logic dn);
        post_cnt = pc; trig_val = tv; trig_mask = tm;
        filt_val = fv; filt_mask = fm; drop_nop = dn;
        arm = 1'b1;
        cyc();
        arm = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input logic [31:0] inst, input logic [1:0] lane);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_inst"},  bus.out_inst, inst);
        chk({tag, "_pc"},    bus.out_pc, inst ^ 32'hFFFF_0000);
        chk({tag, "_lane"},  32'(bus.out_lane), 32'(lane));
        bus.out_ready = 1'b1;
        cyc();
        bus.out_ready = 1'b0;
    endtask

    task automatic pop_br(input string tag, input logic [4:0] ra, input logic [4:0] rb,
                          input logic [11:0] imm, input logic [1:0] lane);
        chk({tag, "_ra"},    32'(bus.out_ra), 32'(ra));
        chk({tag, "_rb"},    32'(bus.out_rb), 32'(rb));
        chk({tag, "_imm"},   32'(bus.out_imm), 32'(imm));
        chk({tag, "_rc"},    32'(bus.out_rc), 32'(imm[4:0]));
        chk({tag, "_shamt"}, 32'(bus.out_shamt), 32'(imm[5:0]));
        pop_chk(tag, mkbr(ra, rb, imm), lane);
    endtask

    initial begin
        reset = 1'b1; arm = 1'b0; disarm = 1'b0; drop_nop = 1'b0;
        post_cnt = '0; trig_val = '0; trig_mask = '0; filt_val = '0; filt_mask = '0;
        bus.ret_valid = '0; bus.ret_pc = '0; bus.ret_inst = '0; bus.out_ready = 1'b0;
        repeat (2) cyc();
        reset = 1'b0;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_trig_idx", 32'(trig_idx), 32'd0);

        // Single-lane history with post_cnt=3, trigger on #30
        do_arm(5'd3, mk(30), 32'hFFFF_FFFF, 7'h00, 7'h00, 1'b0);
        chk("t1_armed", 32'(state), 32'd1);
        chk("t1_cnt0", 32'(count), 32'd0);
        for (int k = 0; k < 40; k++) begin
            drive(2'b01, mk(k), 32'h0);
            if (k == 30) chk("t1_post", 32'(state), 32'd2);
        end
        chk("t1_frozen", 32'(state), 32'd3);
        chk("t1_count", 32'(count), 32'd16);
        chk("t1_trig_idx", 32'(trig_idx), 32'd14);
        repeat (5) cyc();
        chk("t1_stall_count", 32'(count), 32'd16);
        chk("t1_stall_inst", bus.out_inst, mk(18));
        for (int j = 0; j < 16; j++) pop_chk($sformatf("t1_e%0d", j), mk(18 + j), 2'd0);
        chk("t1_empty_count", 32'(count), 32'd0);
        chk("t1_empty_valid", 32'(bus.out_valid), 32'd0);

        // Two-lane bundles, trigger lane 0 with post_cnt=1
        do_arm(5'd1, mk(104), 32'hFFFF_FFFF, 7'h00, 7'h00, 1'b0);
        for (int b = 0; b < 5; b++) drive(2'b11, mk(100 + 2*b), mk(101 + 2*b));
        chk("t2_frozen", 32'(state), 32'd3);
        chk("t2_count", 32'(count), 32'd6);
        chk("t2_trig_idx", 32'(trig_idx), 32'd4);
        arm = 1'b1; disarm = 1'b1;
        cyc();
        arm = 1'b0; disarm = 1'b0;
        chk("t2_armdis_state", 32'(state), 32'd3);
        chk("t2_armdis_count", 32'(count), 32'd6);
        for (int j = 0; j < 6; j++) pop_chk($sformatf("t2_e%0d", j), mk(100 + j), 2'(j % 2));
        chk("t2_empty", 32'(count), 32'd0);

        // Trigger on lane 1 with post_cnt=0 and a full buffer
        do_arm(5'd0, mk(217), 32'hFFFF_FFFF, 7'h00, 7'h00, 1'b0);
        chk("t3_armed", 32'(state), 32'd1);
        chk("t3_cnt0", 32'(count), 32'd0);
        for (int b = 0; b < 10; b++) drive(2'b11, mk(200 + 2*b), mk(201 + 2*b));
        chk("t3_frozen", 32'(state), 32'd3);
        chk("t3_count", 32'(count), 32'd16);
        chk("t3_trig_idx", 32'(trig_idx), 32'd1);
        chk("t3_head", bus.out_inst, mk(202));

        // Opcode filter keeps only branches; fields come from stored inst
        do_arm(5'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, c_op_branch, 7'h7F, 1'b1);
        drive(2'b11, c_nop, mkbr(5'd3, 5'd7, 12'hABC));
        drive(2'b01, {7'h10, 25'h12345}, mkbr(5'd1, 5'd1, 12'h111));
        drive(2'b11, mkbr(5'd31, 5'd0, 12'h03F), c_nop);
        drive(2'b11, c_nop, mkbr(5'd0, 5'd31, 12'hFC1));
        disarm = 1'b1;
        cyc();
        disarm = 1'b0;
        chk("t4_frozen", 32'(state), 32'd3);
        chk("t4_count", 32'(count), 32'd3);
        pop_br("t4_a", 5'd3, 5'd7, 12'hABC, 2'd1);
        pop_br("t4_b", 5'd31, 5'd0, 12'h03F, 2'd0);
        pop_br("t4_c", 5'd0, 5'd31, 12'hFC1, 2'd1);
        chk("t4_empty", 32'(bus.out_valid), 32'd0);

        // NOP drop with filter open, compaction of lane 1 into first slot
        do_arm(5'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 7'h00, 7'h00, 1'b1);
        drive(2'b11, c_nop, mk(300));
        drive(2'b11, mk(301), c_nop);
        disarm = 1'b1;
        cyc();
        disarm = 1'b0;
        chk("t5_count", 32'(count), 32'd2);
        pop_chk("t5_a", mk(300), 2'd1);
        pop_chk("t5_b", mk(301), 2'd0);

        // Reset in the middle of POST
        do_arm(5'd5, mk(404), 32'hFFFF_FFFF, 7'h00, 7'h00, 1'b0);
        for (int k = 400; k < 409; k++) drive(2'b01, mk(k), 32'h0);
        chk("t6_post", 32'(state), 32'd2);
        chk("t6_count", 32'(count), 32'd9);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("t6_rst_state", 32'(state), 32'd0);
        chk("t6_rst_count", 32'(count), 32'd0);
        chk("t6_rst_valid", 32'(bus.out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/inst_trace_buf.md
# inst_trace_buf

Multi-lane retired-instruction trace buffer with trigger and post-trigger capture, for debugging in simulation and on silicon. Sits beside the retire stage. Captures up to LANES instructions per cycle into a circular history, filtered by opcode. Freezes after a programmable post-trigger count and is drained through a valid/ready port that presents each entry already split into its instruction fields.

## Interface
- LANES, 2, retire lanes per cycle (1..4)
- DEPTH, 16, buffer entries; power of two, DEPTH >= 2*LANES
- CW, $clog2(DEPTH), width of pointers; count and post-count ports are CW+1 bits
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ret_valid  in  LANES  per-lane retire valid
- ret_pc  in  32*LANES  lane i at [32i+31:32i]
- ret_inst  in  32*LANES  lane i at [32i+31:32i]
- arm  in  1  pulse: flush buffer, latch config, enter ARMED
- disarm  in  1  pulse: force FROZEN
- post_cnt  in  CW+1  entries to capture after the trigger entry, sampled on arm
- trig_val, trig_mask  in  32 each  trigger on (inst & trig_mask) == (trig_val & trig_mask); sampled on arm
- filt_val, filt_mask  in  7 each  opcode filter on inst[31:25]; sampled on arm
- drop_nop  in  1  discard the NOP encoding; sampled on arm
- out_valid  out  1  entry available
- out_ready  in  1  consumer accepts entry
- out_pc, out_inst  out  32 each  oldest entry
- out_lane  out  2  lane the entry retired on
- out_ra [24:20], out_rb [19:15], out_rc [4:0]  out  5 each
- out_imm [11:0]  out  12;  out_shamt [5:0]  out  6
- count  out  CW+1  occupancy
- state  out  2  IDLE=0, ARMED=1, POST=2, FROZEN=3
- trig_idx  out  CW  buffer position of the trigger entry, valid in POST/FROZEN

## Operation
- Lane accepted iff ret_valid[i], filter match ((op & filt_mask) == (filt_val & filt_mask)) and not (drop_nop && inst == NOP).
- Accepted lanes are compacted in ascending lane order and written in one cycle.
- IDLE: nothing captured. Readout is allowed.
- ARMED: accepted lanes are written. Occupancy is capped at CAP = DEPTH − min(post_cnt_q, DEPTH−1). Overflow advances the head, discarding the oldest entries.
- First accepted lane matching the trigger (lowest lane wins) is written, recorded in trig_idx, and moves the state to POST with remaining = post_cnt_q.
- Lanes above the trigger in the same cycle are written and count against remaining.
- POST: each accepted lane is written and decrements remaining. When remaining reaches 0, the state moves to FROZEN; further lanes in that cycle are discarded.
- If post_cnt_q = 0, the trigger entry is the last one written and the state goes straight to FROZEN.
- POST never overflows: the cap guarantees room.
- FROZEN: no writes.
- out_valid = (count != 0) && state ∈ {IDLE, FROZEN}. A pop occurs on out_valid && out_ready.
- arm in IDLE/FROZEN: clear head/tail/count, latch config, enter ARMED. arm in ARMED/POST is ignored.
- disarm in ARMED/POST → FROZEN with contents kept. disarm in IDLE/FROZEN has no effect.
- arm and disarm in the same cycle: disarm wins.
- Pointers wrap modulo DEPTH. count is exact: 0..DEPTH.

## Timing
- Reset values: state IDLE, count 0, out_valid 0, trig_idx 0, latched config 0. Data outputs are don't-care while out_valid is 0.
- Capture latency is 1: a lane retired in cycle t is in storage at t+1.
- State transitions take effect on the clock edge after the triggering event.
- out_* are combinational from the head entry. Field extraction is combinational from stored inst.
- A pop and count update occur at the edge. The next entry is presented in the following cycle, giving one pop per cycle sustained.
- Reset mid-capture or mid-drain discards everything and returns to IDLE.

## Structure
- Package riscv_trace_pkg holds:
  - the NOP constant (ADDI with all register/immediate fields zero);
  - the field ranges OPCODE 31:25, RA 24:20, RB 19:15, RC 4:0, SHAMT 5:0, IMM 11:0, BIGIMM 19:0, TARGET 26:0;
  - the state enum.
- Sub-module inst_field_unpack: combinational 32-bit inst → ra/rb/rc/shamt/imm/opcode. It is instantiated once per lane for the filter and once on the read port.
- Storage is a DEPTH × (32+32+2) register array with LANES write ports.

## Test plan
- Arm with post_cnt=3, masks 0 (accept all). Stream 40 single-lane instructions, then trigger on #30 → FROZEN after #33. Drain 16 entries #18..#33 with trig_idx pointing at #30.
- LANES=2, both lanes valid every cycle, trigger on lane 0 of a bundle, post_cnt=1 → lane 1 of the same bundle captured, then FROZEN. The next bundle is not captured.
- Trigger on lane 1 with post_cnt=0 → lane 0 and lane 1 written, FROZEN next cycle, count ≤ DEPTH.
- filt_mask=7'h7F, filt_val=BRANCH opcode, drop_nop=1, mixed stream including NOPs → only branches stored. out_ra/out_rb/out_imm match the inst bits.
- Stall out_ready 5 cycles while FROZEN → entries and count hold. Then assert arm and disarm together → stays FROZEN. Then arm alone → count 0, ARMED.
- Assert reset during POST with count=9 → next cycle state IDLE, count 0, out_valid 0.
